// File: rtl/scene_exec_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scene_exec_bank_if                                               |
// | Purpose : Instruction issue and retire handshake bundle for the execute-   |
// |           stage scene memory bank.                                         |
// | Signals : inst_valid/inst_ready/inst_op/inst_addr/inst_data/inst_pc        |
// |           (issue side), retire_valid/retire_ready/retire_pc/retire_op/     |
// |           retire_err (retire side).                                        |
// | Modports: master = instruction source / retire sink, slave = the bank.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface scene_exec_bank_if #(
  parameter int DATA_WIDTH = 160,
  parameter int PC_WIDTH   = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  inst_valid;
  logic                  inst_ready;
  logic [1:0]            inst_op;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [PC_WIDTH-1:0]   inst_pc;
  logic                  retire_valid;
  logic                  retire_ready;
  logic [PC_WIDTH-1:0]   retire_pc;
  logic [1:0]            retire_op;
  logic                  retire_err;

  modport master (
    output inst_valid, inst_op, inst_addr, inst_data, inst_pc, retire_ready,
    input  inst_ready, retire_valid, retire_pc, retire_op, retire_err
  );

  modport slave (
    input  inst_valid, inst_op, inst_addr, inst_data, inst_pc, retire_ready,
    output inst_ready, retire_valid, retire_pc, retire_op, retire_err
  );
endinterface
`default_nettype wire

// File: rtl/scene_exec_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : scene_exec_bank                                                  |
// | Purpose : Execute-stage scene memory bank. Commits camera/light/geometry   |
// |           writes with ready/valid backpressure, retires each accepted      |
// |           instruction with its PC, and serves one light and               |
// |           NUM_GEO_PORTS geometry read ports at READ_LATENCY cycles with    |
// |           write-first bypass. Clears both memories after reset.            |
// | Ports   : clk_100mhz, rst (sync, active-low)                               |
// |           bus               - issue/retire handshake (slave modport)       |
// |           o_memory_ready    - clear sequence finished                      |
// |           o_cur_camera      - current camera register                      |
// |           i/o_light_rd_*    - light read port                              |
// |           i/o_geo_rd_*      - packed geometry read ports, port 0 in LSBs   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module scene_exec_bank #(
  parameter int DATA_WIDTH    = 160,
  parameter int LIGHT_WIDTH   = 96,
  parameter int GEO_WIDTH     = 128,
  parameter int LIGHT_DEPTH   = 8,
  parameter int GEO_DEPTH     = 64,
  parameter int NUM_GEO_PORTS = 2,
  parameter int READ_LATENCY  = 2,
  parameter int PC_WIDTH      = 16
) (
  input  wire                                       clk_100mhz,
  input  wire                                       rst,
  scene_exec_bank_if.slave                          bus,
  output logic                                      o_memory_ready,
  output logic [DATA_WIDTH-1:0]                     o_cur_camera,
  input  wire  [$clog2(LIGHT_DEPTH)-1:0]            i_light_rd_addr,
  output logic [LIGHT_WIDTH-1:0]                    o_light_rd_data,
  input  wire  [NUM_GEO_PORTS*$clog2(GEO_DEPTH)-1:0] i_geo_rd_addr,
  output logic [NUM_GEO_PORTS*GEO_WIDTH-1:0]        o_geo_rd_data
);

  localparam int LA_W = $clog2(LIGHT_DEPTH);
  localparam int GA_W = $clog2(GEO_DEPTH);
  localparam logic [GA_W-1:0] c_GEO_LAST = GA_W'(GEO_DEPTH - 1);
  localparam logic [1:0] c_OP_CAM   = 2'd1;
  localparam logic [1:0] c_OP_LIGHT = 2'd2;
  localparam logic [1:0] c_OP_GEO   = 2'd3;

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [GA_W-1:0]   r_clr_cnt, w_clr_cnt_nxt;
  logic              w_clearing, w_inst_ready, w_memory_ready;

  logic              r_retire_valid;
  logic [PC_WIDTH-1:0] r_retire_pc;
  logic [1:0]        r_retire_op;
  logic              r_retire_err;
  logic [DATA_WIDTH-1:0] r_cur_camera;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_clearing     = 1'b0;
    w_inst_ready   = 1'b0;
    w_memory_ready = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clearing    = 1'b1;
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == c_GEO_LAST) begin
          w_state_nxt   = S_RUN;
          w_clr_cnt_nxt = '0;
        end
      end
      S_RUN: begin
        w_memory_ready = 1'b1;
        // A consumed retire slot frees room for a new instruction this cycle.
        w_inst_ready   = !r_retire_valid || bus.retire_ready;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------- write port
  logic w_accept, w_addr_in_light, w_addr_in_geo, w_inst_err;
  logic w_geo_we, w_light_we;
  logic [GA_W-1:0]        w_geo_waddr;
  logic [LA_W-1:0]        w_light_waddr;
  logic [GEO_WIDTH-1:0]   w_geo_wdata;
  logic [LIGHT_WIDTH-1:0] w_light_wdata;

  assign w_accept        = bus.inst_valid && w_inst_ready;
  assign w_addr_in_light = 32'(bus.inst_addr) < 32'(LIGHT_DEPTH);
  assign w_addr_in_geo   = 32'(bus.inst_addr) < 32'(GEO_DEPTH);
  assign w_inst_err      = ((bus.inst_op == c_OP_LIGHT) && !w_addr_in_light) ||
                           ((bus.inst_op == c_OP_GEO)   && !w_addr_in_geo);

  // Clearing and instruction writes share one port per memory; they never
  // overlap because inst_ready is low while clearing. Reset blocks all writes.
  assign w_geo_we      = rst && (w_clearing ||
                         (w_accept && (bus.inst_op == c_OP_GEO) && w_addr_in_geo));
  assign w_light_we    = rst && ((w_clearing && (32'(r_clr_cnt) < 32'(LIGHT_DEPTH))) ||
                         (w_accept && (bus.inst_op == c_OP_LIGHT) && w_addr_in_light));
  assign w_geo_waddr   = w_clearing ? r_clr_cnt : bus.inst_addr;
  assign w_light_waddr = w_clearing ? r_clr_cnt[LA_W-1:0] : bus.inst_addr[LA_W-1:0];
  assign w_geo_wdata   = w_clearing ? '0 : bus.inst_data[GEO_WIDTH-1:0];
  assign w_light_wdata = w_clearing ? '0 : bus.inst_data[LIGHT_WIDTH-1:0];

  logic [GEO_WIDTH-1:0]   r_geo_mem   [GEO_DEPTH];
  logic [LIGHT_WIDTH-1:0] r_light_mem [LIGHT_DEPTH];

  always_ff @(posedge clk_100mhz) begin
    if (w_geo_we)   r_geo_mem[w_geo_waddr]     <= w_geo_wdata;
    if (w_light_we) r_light_mem[w_light_waddr] <= w_light_wdata;
  end

  // ---------------------------------------------------------------- retire / camera
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      r_retire_valid <= 1'b0;
      r_retire_pc    <= '0;
      r_retire_op    <= '0;
      r_retire_err   <= 1'b0;
      r_cur_camera   <= '0;
    end else begin
      if (w_accept) begin
        r_retire_valid <= 1'b1;
        r_retire_pc    <= bus.inst_pc;
        r_retire_op    <= bus.inst_op;
        r_retire_err   <= w_inst_err;
      end else if (bus.retire_ready) begin
        r_retire_valid <= 1'b0;
      end
      if (w_accept && (bus.inst_op == c_OP_CAM)) r_cur_camera <= bus.inst_data;
    end
  end

  assign bus.inst_ready   = w_inst_ready;
  assign bus.retire_valid = r_retire_valid;
  assign bus.retire_pc    = r_retire_pc;
  assign bus.retire_op    = r_retire_op;
  assign bus.retire_err   = r_retire_err;
  assign o_memory_ready   = w_memory_ready;
  assign o_cur_camera     = r_cur_camera;

  // ---------------------------------------------------------------- light read
  // Stage 0 takes the write landing on this same edge (write-first); the
  // remaining stages are plain delay.
  logic [LIGHT_WIDTH-1:0] w_light_rd;
  logic [LIGHT_WIDTH-1:0] r_light_pipe [READ_LATENCY];

  always_comb begin
    w_light_rd = '0;
    if (32'(i_light_rd_addr) < 32'(LIGHT_DEPTH)) begin
      if (w_light_we && (w_light_waddr == i_light_rd_addr)) w_light_rd = w_light_wdata;
      else                                                    w_light_rd = r_light_mem[i_light_rd_addr];
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      for (int k = 0; k < READ_LATENCY; k++) r_light_pipe[k] <= '0;
    end else begin
      r_light_pipe[0] <= w_light_rd;
      for (int k = 1; k < READ_LATENCY; k++) r_light_pipe[k] <= r_light_pipe[k-1];
    end
  end

  assign o_light_rd_data = r_light_pipe[READ_LATENCY-1];

  // ---------------------------------------------------------------- geometry reads
  generate
    for (genvar p = 0; p < NUM_GEO_PORTS; p++) begin : g_geo_port
      logic [GA_W-1:0]      w_addr;
      logic [GEO_WIDTH-1:0] w_rd;
      logic [GEO_WIDTH-1:0] r_pipe [READ_LATENCY];

      assign w_addr = i_geo_rd_addr[p*GA_W +: GA_W];

      always_comb begin
        w_rd = '0;
        if (32'(w_addr) < 32'(GEO_DEPTH)) begin
          if (w_geo_we && (w_geo_waddr == w_addr)) w_rd = w_geo_wdata;
          else                                      w_rd = r_geo_mem[w_addr];
        end
      end

      always_ff @(posedge clk_100mhz) begin
        if (!rst) begin
          for (int k = 0; k < READ_LATENCY; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= w_rd;
          for (int k = 1; k < READ_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign o_geo_rd_data[p*GEO_WIDTH +: GEO_WIDTH] = r_pipe[READ_LATENCY-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_scene_exec_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_scene_exec_bank                                               |
// | Purpose : Self-checking bench for scene_exec_bank: directed vector table   |
// |           plus hand sequences for clear timing, bypass, throughput,        |
// |           backpressure and mid-operation reset.                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_scene_exec_bank;
  localparam int DW = 160, LW = 96, GW = 128, LD = 8, GD = 64;
  localparam int NP = 2, RL = 2, PW = 16, GA = 6, LA = 3;

  logic clk_100mhz = 1'b0;
  logic rst;
  always #5 clk_100mhz = ~clk_100mhz;

  scene_exec_bank_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .ADDR_WIDTH(GA)) bus ();

  logic          memory_ready;
  logic [DW-1:0] cur_camera;
  logic [LA-1:0] light_rd_addr;
  logic [LW-1:0] light_rd_data;
  logic [NP*GA-1:0] geo_rd_addr;
  logic [NP*GW-1:0] geo_rd_data;

  scene_exec_bank #(
    .DATA_WIDTH(DW), .LIGHT_WIDTH(LW), .GEO_WIDTH(GW), .LIGHT_DEPTH(LD),
    .GEO_DEPTH(GD), .NUM_GEO_PORTS(NP), .READ_LATENCY(RL), .PC_WIDTH(PW)
  ) dut (
    .clk_100mhz      (clk_100mhz),
    .rst             (rst),
    .bus             (bus),
    .o_memory_ready  (memory_ready),
    .o_cur_camera    (cur_camera),
    .i_light_rd_addr (light_rd_addr),
    .o_light_rd_data (light_rd_data),
    .i_geo_rd_addr   (geo_rd_addr),
    .o_geo_rd_data   (geo_rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic drive_inst(input logic [1:0] op, input logic [GA-1:0] addr,
                            input logic [DW-1:0] data, input logic [PW-1:0] pc);
    bus.inst_valid = 1'b1;
    bus.inst_op    = op;
    bus.inst_addr  = addr;
    bus.inst_data  = data;
    bus.inst_pc    = pc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inst_ready"},   DW'(bus.inst_ready),   '0);
    chk({tag, "_retire_valid"}, DW'(bus.retire_valid), '0);
    chk({tag, "_retire_pc"},    DW'(bus.retire_pc),    '0);
    chk({tag, "_retire_op"},    DW'(bus.retire_op),    '0);
    chk({tag, "_retire_err"},   DW'(bus.retire_err),   '0);
    chk({tag, "_memory_ready"}, DW'(memory_ready),     '0);
    chk({tag, "_cur_camera"},   cur_camera,            '0);
    chk({tag, "_light_rd"},     DW'(light_rd_data),    '0);
    chk({tag, "_geo_rd"},       DW'(geo_rd_data),      '0);
  endtask

  task automatic count_clear(input string tag);
    int cyc;
    cyc = 0;
    while (!memory_ready && cyc < 200) begin
      step();
      cyc++;
    end
    chk({tag, "_clear_cycles"}, DW'(cyc), DW'(64));
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [GA-1:0] addr;
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic          exp_err;
    logic [1:0]    rd_sel;   // 0 geo port0, 1 geo port1, 2 light, 3 camera
    logic [GA-1:0] rd_addr;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] act;
    vecs[0] = '{2'd3, 6'd20, DW'(32'h1111_2222), 16'h0040, 1'b0, 2'd0, 6'd20, DW'(32'h1111_2222)};
    vecs[1] = '{2'd3, 6'd63, {32'hDEAD_BEEF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210},
                16'h0041, 1'b0, 2'd1, 6'd63, DW'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210)};
    vecs[2] = '{2'd2, 6'd7, {64'hCAFE_F00D_CAFE_F00D, 96'hA5A5_A5A5_5A5A_5A5A_0102_0304},
                16'h0042, 1'b0, 2'd2, 6'd7, DW'(96'hA5A5_A5A5_5A5A_5A5A_0102_0304)};
    vecs[3] = '{2'd2, 6'd9, DW'(16'hDEAD), 16'h0043, 1'b1, 2'd2, 6'd1, DW'(0)};
    vecs[4] = '{2'd1, 6'd0, DW'(16'h1234), 16'h0044, 1'b0, 2'd3, 6'd0, DW'(16'h1234)};
    vecs[5] = '{2'd0, 6'd63, DW'(16'h9999), 16'h0045, 1'b0, 2'd1, 6'd63,
                DW'(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210)};
    vecs[6] = '{2'd3, 6'd0, DW'(16'h5555), 16'h0046, 1'b0, 2'd0, 6'd0, DW'(16'h5555)};
    vecs[7] = '{2'd1, 6'd0, {32'hFEED_F00D, 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788},
                16'h0047, 1'b0, 2'd3, 6'd0,
                {32'hFEED_F00D, 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788}};

    rst = 1'b0;
    bus.inst_valid = 1'b0; bus.inst_op = '0; bus.inst_addr = '0;
    bus.inst_data = '0; bus.inst_pc = '0; bus.retire_ready = 1'b1;
    light_rd_addr = '0; geo_rd_addr = '0;
    step(); step();
    chk_all_zero("reset");

    // Clear sequence length and cleared contents.
    rst = 1'b0;
    rst = 1'b1;
    count_clear("init");
    geo_rd_addr[5:0] = 6'd63;
    light_rd_addr    = 3'd7;
    step(); step();
    chk("clear_geo63",  DW'(geo_rd_data[GW-1:0]), '0);
    chk("clear_light7", DW'(light_rd_data),       '0);

    // Same-cycle write/read bypass on port 1, neighbour on port 0.
    drive_inst(2'd3, 6'd5, DW'(16'hABCD), 16'h0010);
    geo_rd_addr = {6'd5, 6'd4};
    chk("bypass_ready", DW'(bus.inst_ready), DW'(1));
    step();
    bus.inst_valid = 1'b0;
    geo_rd_addr = {6'd0, 6'd0};
    step();
    chk("bypass_port1", DW'(geo_rd_data[2*GW-1:GW]), DW'(16'hABCD));
    chk("bypass_port0", DW'(geo_rd_data[GW-1:0]),    '0);

    // Table-driven write / retire / readback.
    for (int i = 0; i < 8; i++) begin
      drive_inst(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].pc);
      chk($sformatf("v%0d_ready", i), DW'(bus.inst_ready), DW'(1));
      step();
      bus.inst_valid = 1'b0;
      chk($sformatf("v%0d_rvalid", i), DW'(bus.retire_valid), DW'(1));
      chk($sformatf("v%0d_rpc", i),    DW'(bus.retire_pc),    DW'(vecs[i].pc));
      chk($sformatf("v%0d_rop", i),    DW'(bus.retire_op),    DW'(vecs[i].op));
      chk($sformatf("v%0d_rerr", i),   DW'(bus.retire_err),   DW'(vecs[i].exp_err));
      case (vecs[i].rd_sel)
        2'd0: geo_rd_addr[GA-1:0]    = vecs[i].rd_addr;
        2'd1: geo_rd_addr[2*GA-1:GA] = vecs[i].rd_addr;
        2'd2: light_rd_addr          = vecs[i].rd_addr[LA-1:0];
        default: ;
      endcase
      step(); step();
      case (vecs[i].rd_sel)
        2'd0: act = DW'(geo_rd_data[GW-1:0]);
        2'd1: act = DW'(geo_rd_data[2*GW-1:GW]);
        2'd2: act = DW'(light_rd_data);
        default: act = cur_camera;
      endcase
      chk($sformatf("v%0d_readback", i), act, vecs[i].exp_rd);
    end

    // Back-to-back throughput.
    bus.retire_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_inst(2'd3, GA'(10 + i), DW'(i), PW'(16'h0100 + i));
      chk($sformatf("b2b_ready%0d", i), DW'(bus.inst_ready), DW'(1));
      step();
      chk($sformatf("b2b_rvalid%0d", i), DW'(bus.retire_valid), DW'(1));
      chk($sformatf("b2b_rpc%0d", i),    DW'(bus.retire_pc),    DW'(16'h0100 + i));
    end
    bus.inst_valid = 1'b0;
    step();
    chk("b2b_drain", DW'(bus.retire_valid), '0);

    // Retire backpressure.
    bus.retire_ready = 1'b0;
    drive_inst(2'd2, 6'd2, DW'(8'h55), 16'h0020);
    chk("stall_first_ready", DW'(bus.inst_ready), DW'(1));
    step();
    drive_inst(2'd3, 6'd40, DW'(8'h66), 16'h0021);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("stall_ready%0d", j), DW'(bus.inst_ready),   '0);
      chk($sformatf("stall_rpc%0d", j),   DW'(bus.retire_pc),    DW'(16'h0020));
      chk($sformatf("stall_rvld%0d", j),  DW'(bus.retire_valid), DW'(1));
      step();
    end
    bus.retire_ready = 1'b1;
    #1;
    chk("release_ready", DW'(bus.inst_ready), DW'(1));
    step();
    bus.inst_valid = 1'b0;
    chk("release_rpc", DW'(bus.retire_pc), DW'(16'h0021));
    chk("release_rop", DW'(bus.retire_op), DW'(3));
    step();

    // Reset during a retire stall with reads in flight.
    geo_rd_addr[GA-1:0] = 6'd20;
    light_rd_addr = 3'd7;
    bus.retire_ready = 1'b0;
    drive_inst(2'd2, 6'd3, DW'(8'h77), 16'h0050);
    step();
    bus.inst_valid = 1'b0;
    step();
    chk("pre_rst_geo20", DW'(geo_rd_data[GW-1:0]), DW'(32'h1111_2222));
    chk("pre_rst_rpc",   DW'(bus.retire_pc),       DW'(16'h0050));
    rst = 1'b0;
    step();
    chk_all_zero("midrst");
    rst = 1'b1;
    bus.retire_ready = 1'b1;
    count_clear("midrst");
    step(); step();
    chk("post_rst_geo20",  DW'(geo_rd_data[GW-1:0]), '0);
    chk("post_rst_light7", DW'(light_rd_data),       '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/scene_exec_bank.md
Name: scene_exec_bank

Overview:
Parametrised successor to the execute-stage scene memory bank. Commits camera, light and geometry write instructions with ready/valid backpressure and retires each accepted instruction with its PC. Serves one light read port and NUM_GEO_PORTS geometry read ports at a configurable fixed latency, with write-first bypass. Runs a clear sequence after reset before accepting instructions.

Parameters:
DATA_WIDTH, 160, instruction payload width (camera uses all bits; light and geometry use LSBs)
LIGHT_WIDTH, 96, light entry width (<= DATA_WIDTH)
GEO_WIDTH, 128, geometry entry width (<= DATA_WIDTH)
LIGHT_DEPTH, 8, light entries (<= GEO_DEPTH)
GEO_DEPTH, 64, geometry entries
NUM_GEO_PORTS, 2, geometry read ports (>= 1)
READ_LATENCY, 2, read address-to-data cycles (>= 1)
PC_WIDTH, 16, instruction address width

Ports:
clk_100mhz  in  1  clock
rst  in  1  synchronous reset, active-low
inst_valid  in  1  instruction offered
inst_ready  out  1  instruction accepted when high with inst_valid
inst_op  in  2  0=NOP, 1=CAM_WR, 2=LIGHT_WR, 3=GEO_WR
inst_addr  in  $clog2(GEO_DEPTH)  entry index (ignored for CAM_WR/NOP)
inst_data  in  DATA_WIDTH  write payload
inst_pc  in  PC_WIDTH  instruction PC
retire_valid  out  1  retired instruction present
retire_ready  in  1  downstream consumes retire slot
retire_pc  out  PC_WIDTH  PC of retired instruction
retire_op  out  2  op of retired instruction
retire_err  out  1  write address out of range
memory_ready  out  1  clear done, bank serving
cur_camera  out  DATA_WIDTH  current camera register
light_rd_addr  in  $clog2(LIGHT_DEPTH)  light read address
light_rd_data  out  LIGHT_WIDTH  light read data
geo_rd_addr  in  NUM_GEO_PORTS*$clog2(GEO_DEPTH)  packed geometry read addresses, port 0 in LSBs
geo_rd_data  out  NUM_GEO_PORTS*GEO_WIDTH  packed geometry read data, port 0 in LSBs

Behaviour:
- Reset (rst==0 at a clk_100mhz edge):
  - All outputs go to 0: inst_ready, retire_valid, retire_pc, retire_op, retire_err, memory_ready, cur_camera, light_rd_data, geo_rd_data.
  - Read pipelines flush. FSM enters CLEAR with the clear counter at 0.
  - Reset mid-operation discards in-flight reads and the retire slot; the clear sequence restarts from 0.
- FSM CLEAR:
  - Each cycle, write zero to geometry[cnt], and to light[cnt] when cnt < LIGHT_DEPTH.
  - cnt increments; after cnt == GEO_DEPTH-1 go to RUN (exactly GEO_DEPTH cycles).
  - inst_ready=0 and memory_ready=0 throughout CLEAR. Reads still return data; no valid qualifier is implied.
- FSM RUN:
  - memory_ready=1.
  - inst_ready = !retire_valid || retire_ready (combinational). A downstream stall blocks acceptance.
- Acceptance (inst_valid && inst_ready):
  - The write commits at that edge.
  - CAM_WR: cur_camera <= inst_data, visible next cycle.
  - LIGHT_WR: writes light[addr] with inst_data[LIGHT_WIDTH-1:0].
  - GEO_WR: writes geometry[addr] with inst_data[GEO_WIDTH-1:0].
  - Out-of-range address (addr >= depth): no write; retire_err=1.
- Retire:
  - Retire registers load on acceptance; retire_valid=1 in the next cycle.
  - Retire registers hold while retire_valid && !retire_ready.
  - retire_valid clears when retire_ready is high and there is no new acceptance.
  - Simultaneous consume and accept replaces the slot (back-to-back throughput of 1/cycle).
- Reads:
  - The address sampled at edge t produces data at edge t+READ_LATENCY. Fully pipelined; a new address is accepted every cycle.
  - Write-first: data reflects every write accepted at edge <= t, including a write to the same address at edge t (bypass compare in stage 1).
  - All geometry ports are independent; equal addresses on several ports are legal and return identical data.
  - Out-of-range read address returns 0.
- Writes during CLEAR cannot occur because inst_ready=0.

Test Plan:
- Reset then idle: count cycles until memory_ready=1 -> exactly 64 cycles after rst deasserts. Read geo[63] and light[7] -> 0 at latency 2.
- GEO_WR addr=5 data=0xABCD and same-cycle read port1 addr=5 -> geo_rd_data port1 = 0xABCD two cycles later. Port0 reading addr=4 -> 0.
- Ten back-to-back GEO_WRs, pc=0x100..0x109, with retire_ready=1 -> retire_valid high 10 consecutive cycles with pc incrementing. inst_ready stays 1.
- retire_ready held 0 for 3 cycles after one accepted LIGHT_WR pc=0x20 -> inst_ready=0, retire_pc holds 0x20. Release -> next instruction is accepted the same cycle.
- LIGHT_WR addr=9 (>= 8) -> retire_err=1; light contents unchanged. CAM_WR data=0x1234 -> cur_camera=0x1234 next cycle.
- Assert rst during the retire stall and with reads in flight -> all outputs 0 next cycle. memory_ready returns after 64 cycles. Previously written geometry reads 0.
